decoder_pipelined: RTL and testbench
====================================

# decoder_pipelined

Registered, parametrised instruction-decode stage for the MIPS pipeline, sitting between the IF/ID latch and the register file/EX stage. It decodes the full supported instruction set (R-type, shifts, jumps, branches, immediates, loads, stores) into register addresses, an extended immediate and control bits, and holds them in an ID/EX output register. The stage detects load-use hazards and inserts bubbles, and it supports flush, external stall and debug-step enable.

## Interface
- CANT_BITS_INSTRUCCION, 32, instruction and extended-immediate width
- CANT_BITS_ADDRESS_REGISTROS, 5, register address width
- CANT_BITS_IMMEDIATE, 16, raw immediate field width
- CANT_BITS_INSTRUCTION_INDEX_BRANCH, 26, jump index width
- CANT_BITS_FLAG_BRANCH, 3, branch-type code width
- CANT_BITS_ADDR, 11, PC width
- CANT_BITS_CONTADOR, 16, hazard counter width

Ports:
- i_clock  in  1  clock; all state on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  step enable; 0 holds all state
- i_valid  in  1  i_instruction/i_pc valid
- i_instruction  in  CANT_BITS_INSTRUCCION  instruction from IF/ID
- i_pc  in  CANT_BITS_ADDR  PC+1 of the instruction
- i_flush  in  1  kill the incoming instruction (taken branch/jump)
- i_stall_ext  in  1  downstream stall; hold the output register
- o_stall_fetch  out  1  hold IF and IF/ID this cycle (combinational)
- o_valid  out  1  output register holds a real instruction
- o_reg_A, o_reg_B, o_reg_W  out  CANT_BITS_ADDRESS_REGISTROS  rs, rt, resolved destination
- o_flag_branch  out  CANT_BITS_FLAG_BRANCH  000 none, 001 JR, 010 JALR, 011 BEQ, 100 BNE, 101 J, 110 JAL
- o_immediate  out  CANT_BITS_INSTRUCCION  extended immediate
- o_instruction_index_branch  out  CANT_BITS_INSTRUCTION_INDEX_BRANCH  bits [25:0]
- o_pc  out  CANT_BITS_ADDR  registered i_pc
- o_reg_write, o_mem_read, o_mem_write  out  1  control bits
- o_hazard_count  out  CANT_BITS_CONTADOR  saturating count of inserted load-use bubbles

## Operation
- Opcode bits [31:26], funct bits [5:0].
- Opcode 0, funct 0/2/3 (SLL/SRL/SRA):
  - o_reg_W=rd, reg_write=1
  - immediate = shamt [10:6] zero-extended
  - source: rt only (uses_A=0)
- Opcode 0, funct 8 (JR): flag 001, reg_write=0, uses_A.
- Opcode 0, funct 9 (JALR): flag 010, reg_W=rd, reg_write=1, uses_A.
- Opcode 0, other funct: R-type, reg_W=rd, reg_write=1, uses_A and uses_B.
- Opcode 4/5 (BEQ/BNE): flag 011/100, sign-extended immediate, uses_A and uses_B, reg_write=0.
- Opcode 2 (J): flag 101.
- Opcode 3 (JAL): flag 110, reg_W=31, reg_write=1.
- Opcodes 8, 10 (ADDI, SLTI): sign-extend. Opcodes 12–14 (ANDI/ORI/XORI): zero-extend. All: reg_W=rt, reg_write=1, uses_A.
- Opcode 15 (LUI): immediate = imm<<16, reg_W=rt, reg_write=1.
- Opcodes 32, 33, 35, 36, 37, 39 (loads): mem_read=1, reg_write=1, reg_W=rt, sign-extended offset, uses_A.
- Opcodes 40, 41, 43 (stores): mem_write=1, sign-extended offset, uses_A and uses_B.
- Any other opcode is a NOP: all controls 0, flag 000, fields passed through.
- reg_W=0 forces reg_write=0.
- hazard = i_valid & o_valid & o_mem_read & (o_reg_W≠0) & ((uses_A & rs==o_reg_W) | (uses_B & rt==o_reg_W)).
- Register update priority, highest first:
  1. reset: all outputs 0
  2. i_enable=0: hold everything
  3. i_flush: load a bubble
  4. i_stall_ext: hold
  5. hazard: load a bubble, counter+1, saturating at all-ones
  6. otherwise: load the decoded instruction, o_valid=i_valid
- A bubble sets o_valid=0, o_reg_write/o_mem_read/o_mem_write=0, o_flag_branch=000. Data fields are don't-care, and 0 is the required value.
- o_stall_fetch = i_enable & ~i_flush & (i_stall_ext | hazard).

## Timing
- Decode-to-output latency is 1 cycle. o_stall_fetch is combinational in the same cycle.
- Reset: every output reads 0 asynchronously on i_reset=0. It releases synchronously; the first capture happens on the first rising edge with i_reset=1.
- A load-use hazard stalls for exactly 1 cycle. After the bubble, o_mem_read=0, so the held instruction issues on the next edge.
- Flush and hazard in the same cycle: flush wins. There is no stall and no count increment.
- Flush and i_stall_ext in the same cycle: flush wins; the output becomes a bubble.
- Reset asserted during a stall: outputs go to 0 and the counter clears. There is no residual stall after release.

## Structure
- Package decoder_pkg holds:
  - opcode and funct constants
  - the o_flag_branch codes
  - the extension-mode enum (SIGN, ZERO, SHAMT, LUI)
- Sub-module decoder_core is purely combinational. It maps an instruction to fields, controls, uses_A/uses_B and the extended immediate.
- decoder_pipelined adds the output register, the hazard logic and the counter.

## Test plan
- After reset, LW $5,4($1) (0x8C250004): next edge gives o_mem_read=1, o_reg_W=5, o_immediate=0x00000004, o_valid=1.
- LW $5 then ADD $6,$5,$2: o_stall_fetch=1 for one cycle, bubble o_valid=0, o_hazard_count=1. The ADD issues on the following edge.
- LW $0 followed by a use of $0: no stall, no count.
- JAL 0x0000010: o_flag_branch=110, o_reg_W=31, o_reg_write=1. ANDI $3,$3,0x8001 gives o_immediate=0x00008001. ADDI with 0x8001 gives 0xFFFF8001.
- Hazard with i_flush=1 in the same cycle: bubble, o_stall_fetch=0, counter unchanged. With i_enable=0: outputs held for any stimulus.
- Assert i_reset=0 mid-stall: all outputs 0 immediately. Drive the counter to 0xFFFF: a further hazard keeps it at 0xFFFF.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_pkg : opcode/funct encodings, branch-flag codes, extension modes
// Rev 1.0
// ---------------------------------------------------------------------------
package decoder_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'd0;
   localparam logic [5:0] OP_J       = 6'd2;
   localparam logic [5:0] OP_JAL     = 6'd3;
   localparam logic [5:0] OP_BEQ     = 6'd4;
   localparam logic [5:0] OP_BNE     = 6'd5;
   localparam logic [5:0] OP_ADDI    = 6'd8;
   localparam logic [5:0] OP_SLTI    = 6'd10;
   localparam logic [5:0] OP_ANDI    = 6'd12;
   localparam logic [5:0] OP_ORI     = 6'd13;
   localparam logic [5:0] OP_XORI    = 6'd14;
   localparam logic [5:0] OP_LUI     = 6'd15;
   localparam logic [5:0] OP_LB      = 6'd32;
   localparam logic [5:0] OP_LH      = 6'd33;
   localparam logic [5:0] OP_LW      = 6'd35;
   localparam logic [5:0] OP_LBU     = 6'd36;
   localparam logic [5:0] OP_LHU     = 6'd37;
   localparam logic [5:0] OP_LWU     = 6'd39;
   localparam logic [5:0] OP_SB      = 6'd40;
   localparam logic [5:0] OP_SH      = 6'd41;
   localparam logic [5:0] OP_SW      = 6'd43;

   localparam logic [5:0] FN_SLL     = 6'd0;
   localparam logic [5:0] FN_SRL     = 6'd2;
   localparam logic [5:0] FN_SRA     = 6'd3;
   localparam logic [5:0] FN_JR      = 6'd8;
   localparam logic [5:0] FN_JALR    = 6'd9;

   localparam logic [2:0] BR_NONE    = 3'b000;
   localparam logic [2:0] BR_JR      = 3'b001;
   localparam logic [2:0] BR_JALR    = 3'b010;
   localparam logic [2:0] BR_BEQ     = 3'b011;
   localparam logic [2:0] BR_BNE     = 3'b100;
   localparam logic [2:0] BR_J       = 3'b101;
   localparam logic [2:0] BR_JAL     = 3'b110;

   typedef enum logic [1:0] {
      EXT_SIGN  = 2'd0,
      EXT_ZERO  = 2'd1,
      EXT_SHAMT = 2'd2,
      EXT_LUI   = 2'd3
   } ext_mode_e;

endpackage
`default_nettype wire

// File: rtl/decoder_pipelined_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_core : combinational MIPS instruction field/control decoder
// Rev 1.0
// ---------------------------------------------------------------------------
module decoder_core
   import decoder_pkg::*;
#(
   parameter int CANT_BITS_INSTRUCCION              = 32,
   parameter int CANT_BITS_ADDRESS_REGISTROS        = 5,
   parameter int CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26
) (
   input  logic [CANT_BITS_INSTRUCCION-1:0]              instruction_i,
   output logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        reg_a_o,
   output logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        reg_b_o,
   output logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        reg_w_o,
   output logic [2:0]                                    flag_branch_o,
   output logic [CANT_BITS_INSTRUCCION-1:0]              immediate_o,
   output logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] index_o,
   output logic                                          reg_write_o,
   output logic                                          mem_read_o,
   output logic                                          mem_write_o,
   output logic                                          uses_a_o,
   output logic                                          uses_b_o
);

   localparam int W = CANT_BITS_INSTRUCCION;

   logic [5:0]                             w_opcode;
   logic [5:0]                             w_funct;
   logic [15:0]                            w_imm;
   logic [CANT_BITS_ADDRESS_REGISTROS-1:0] w_rd;
   logic                                   w_wr;
   ext_mode_e                              w_ext;

   assign w_opcode = instruction_i[31:26];
   assign w_funct  = instruction_i[5:0];
   assign w_imm    = instruction_i[15:0];
   assign w_rd     = instruction_i[15:11];
   assign reg_a_o  = instruction_i[25:21];
   assign reg_b_o  = instruction_i[20:16];
   assign index_o  = instruction_i[25:0];

   always_comb begin
      reg_w_o       = instruction_i[20:16];
      flag_branch_o = BR_NONE;
      w_wr          = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      uses_a_o      = 1'b0;
      uses_b_o      = 1'b0;
      w_ext         = EXT_SIGN;
      case (w_opcode)
         OP_SPECIAL: begin
            case (w_funct)
               FN_SLL, FN_SRL, FN_SRA: begin
                  reg_w_o  = w_rd;
                  w_wr     = 1'b1;
                  w_ext    = EXT_SHAMT;
                  uses_b_o = 1'b1;
               end
               FN_JR: begin
                  flag_branch_o = BR_JR;
                  uses_a_o      = 1'b1;
               end
               FN_JALR: begin
                  flag_branch_o = BR_JALR;
                  reg_w_o       = w_rd;
                  w_wr          = 1'b1;
                  uses_a_o      = 1'b1;
               end
               default: begin
                  reg_w_o  = w_rd;
                  w_wr     = 1'b1;
                  uses_a_o = 1'b1;
                  uses_b_o = 1'b1;
               end
            endcase
         end
         OP_BEQ, OP_BNE: begin
            flag_branch_o = (w_opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
            uses_a_o      = 1'b1;
            uses_b_o      = 1'b1;
         end
         OP_J: flag_branch_o = BR_J;
         OP_JAL: begin
            flag_branch_o = BR_JAL;
            reg_w_o       = '1;
            w_wr          = 1'b1;
         end
         OP_ADDI, OP_SLTI: begin
            w_wr     = 1'b1;
            uses_a_o = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            w_ext    = EXT_ZERO;
            w_wr     = 1'b1;
            uses_a_o = 1'b1;
         end
         OP_LUI: begin
            w_ext = EXT_LUI;
            w_wr  = 1'b1;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
            mem_read_o = 1'b1;
            w_wr       = 1'b1;
            uses_a_o   = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: begin
            mem_write_o = 1'b1;
            uses_a_o    = 1'b1;
            uses_b_o    = 1'b1;
         end
         default: ;
      endcase
   end

   // Writes to $0 are architecturally discarded, so never advertise them.
   assign reg_write_o = w_wr & (reg_w_o != '0);

   always_comb begin
      case (w_ext)
         EXT_ZERO:  immediate_o = {{(W-16){1'b0}}, w_imm};
         EXT_SHAMT: immediate_o = {{(W-5){1'b0}}, instruction_i[10:6]};
         EXT_LUI:   immediate_o = {{(W-16){1'b0}}, w_imm} << 16;
         default:   immediate_o = {{(W-16){w_imm[15]}}, w_imm};
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/decoder_pipelined.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_pipelined : ID stage with ID/EX register, load-use bubbles, counter
// Rev 1.0
// ---------------------------------------------------------------------------
module decoder_pipelined
   import decoder_pkg::*;
#(
   parameter int CANT_BITS_INSTRUCCION              = 32,
   parameter int CANT_BITS_ADDRESS_REGISTROS        = 5,
   parameter int CANT_BITS_IMMEDIATE                = 16,
   parameter int CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
   parameter int CANT_BITS_FLAG_BRANCH              = 3,
   parameter int CANT_BITS_ADDR                     = 11,
   parameter int CANT_BITS_CONTADOR                 = 16
) (
   input  logic                                          i_clock,
   input  logic                                          i_reset,
   input  logic                                          i_enable,
   input  logic                                          i_valid,
   input  logic [CANT_BITS_INSTRUCCION-1:0]              i_instruction,
   input  logic [CANT_BITS_ADDR-1:0]                     i_pc,
   input  logic                                          i_flush,
   input  logic                                          i_stall_ext,
   output logic                                          o_stall_fetch,
   output logic                                          o_valid,
   output logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        o_reg_A,
   output logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        o_reg_B,
   output logic [CANT_BITS_ADDRESS_REGISTROS-1:0]        o_reg_W,
   output logic [CANT_BITS_FLAG_BRANCH-1:0]              o_flag_branch,
   output logic [CANT_BITS_INSTRUCCION-1:0]              o_immediate,
   output logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] o_instruction_index_branch,
   output logic [CANT_BITS_ADDR-1:0]                     o_pc,
   output logic                                          o_reg_write,
   output logic                                          o_mem_read,
   output logic                                          o_mem_write,
   output logic [CANT_BITS_CONTADOR-1:0]                 o_hazard_count
);

   localparam int RW = CANT_BITS_ADDRESS_REGISTROS;

   logic [RW-1:0]                                 w_ra, w_rb, w_rw;
   logic [2:0]                                    w_flag;
   logic [CANT_BITS_INSTRUCCION-1:0]              w_imm;
   logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] w_index;
   logic                                          w_wr, w_mr, w_mw, w_uses_a, w_uses_b;
   logic                                          w_hazard;

   logic                                          valid_q, valid_d;
   logic [RW-1:0]                                 reg_a_q, reg_a_d, reg_b_q, reg_b_d, reg_w_q, reg_w_d;
   logic [CANT_BITS_FLAG_BRANCH-1:0]              flag_q, flag_d;
   logic [CANT_BITS_INSTRUCCION-1:0]              imm_q, imm_d;
   logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] index_q, index_d;
   logic [CANT_BITS_ADDR-1:0]                     pc_q, pc_d;
   logic                                          wr_q, wr_d, mr_q, mr_d, mw_q, mw_d;
   logic [CANT_BITS_CONTADOR-1:0]                 count_q, count_d;

   decoder_core #(
      .CANT_BITS_INSTRUCCION              (CANT_BITS_INSTRUCCION),
      .CANT_BITS_ADDRESS_REGISTROS        (CANT_BITS_ADDRESS_REGISTROS),
      .CANT_BITS_INSTRUCTION_INDEX_BRANCH (CANT_BITS_INSTRUCTION_INDEX_BRANCH)
   ) u_core (
      .instruction_i (i_instruction),
      .reg_a_o       (w_ra),
      .reg_b_o       (w_rb),
      .reg_w_o       (w_rw),
      .flag_branch_o (w_flag),
      .immediate_o   (w_imm),
      .index_o       (w_index),
      .reg_write_o   (w_wr),
      .mem_read_o    (w_mr),
      .mem_write_o   (w_mw),
      .uses_a_o      (w_uses_a),
      .uses_b_o      (w_uses_b)
   );

   // Load in ID/EX whose destination is read by the incoming instruction.
   assign w_hazard = i_valid & valid_q & mr_q & (reg_w_q != '0) &
                     ((w_uses_a & (w_ra == reg_w_q)) | (w_uses_b & (w_rb == reg_w_q)));

   assign o_stall_fetch = i_enable & ~i_flush & (i_stall_ext | w_hazard);

   always_comb begin
      valid_d = valid_q;
      reg_a_d = reg_a_q;
      reg_b_d = reg_b_q;
      reg_w_d = reg_w_q;
      flag_d  = flag_q;
      imm_d   = imm_q;
      index_d = index_q;
      pc_d    = pc_q;
      wr_d    = wr_q;
      mr_d    = mr_q;
      mw_d    = mw_q;
      count_d = count_q;
      if (i_enable && !i_stall_ext || i_enable && i_flush) begin
         if (i_flush || w_hazard) begin
            valid_d = 1'b0;
            reg_a_d = '0;
            reg_b_d = '0;
            reg_w_d = '0;
            flag_d  = '0;
            imm_d   = '0;
            index_d = '0;
            pc_d    = '0;
            wr_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            if (!i_flush && (count_q != '1)) count_d = count_q + 1'b1;
         end else begin
            valid_d = i_valid;
            reg_a_d = w_ra;
            reg_b_d = w_rb;
            reg_w_d = w_rw;
            flag_d  = i_valid ? w_flag : '0;
            imm_d   = w_imm;
            index_d = w_index;
            pc_d    = i_pc;
            wr_d    = i_valid & w_wr;
            mr_d    = i_valid & w_mr;
            mw_d    = i_valid & w_mw;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         valid_q <= 1'b0;
         reg_a_q <= '0;
         reg_b_q <= '0;
         reg_w_q <= '0;
         flag_q  <= '0;
         imm_q   <= '0;
         index_q <= '0;
         pc_q    <= '0;
         wr_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         reg_a_q <= reg_a_d;
         reg_b_q <= reg_b_d;
         reg_w_q <= reg_w_d;
         flag_q  <= flag_d;
         imm_q   <= imm_d;
         index_q <= index_d;
         pc_q    <= pc_d;
         wr_q    <= wr_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         count_q <= count_d;
      end
   end

   assign o_valid                    = valid_q;
   assign o_reg_A                    = reg_a_q;
   assign o_reg_B                    = reg_b_q;
   assign o_reg_W                    = reg_w_q;
   assign o_flag_branch              = flag_q;
   assign o_immediate                = imm_q;
   assign o_instruction_index_branch = index_q;
   assign o_pc                       = pc_q;
   assign o_reg_write                = wr_q;
   assign o_mem_read                 = mr_q;
   assign o_mem_write                = mw_q;
   assign o_hazard_count             = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipelined.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decoder_pipelined : scoreboard bench for the ID stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_decoder_pipelined;

   // Narrow counter so saturation is reachable in a short run.
   localparam int CW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_enable, i_valid, i_flush, i_stall_ext;
   logic [31:0] i_instruction;
   logic [10:0] i_pc;
   logic        o_stall_fetch, o_valid, o_reg_write, o_mem_read, o_mem_write;
   logic [4:0]  o_reg_A, o_reg_B, o_reg_W;
   logic [2:0]  o_flag_branch;
   logic [31:0] o_immediate;
   logic [25:0] o_index;
   logic [10:0] o_pc;
   logic [CW-1:0] o_hazard_count;

   always #5 clk = ~clk;

   decoder_pipelined #(.CANT_BITS_CONTADOR(CW)) dut (
      .i_clock                    (clk),
      .i_reset                    (rst_n),
      .i_enable                   (i_enable),
      .i_valid                    (i_valid),
      .i_instruction              (i_instruction),
      .i_pc                       (i_pc),
      .i_flush                    (i_flush),
      .i_stall_ext                (i_stall_ext),
      .o_stall_fetch              (o_stall_fetch),
      .o_valid                    (o_valid),
      .o_reg_A                    (o_reg_A),
      .o_reg_B                    (o_reg_B),
      .o_reg_W                    (o_reg_W),
      .o_flag_branch              (o_flag_branch),
      .o_immediate                (o_immediate),
      .o_instruction_index_branch (o_index),
      .o_pc                       (o_pc),
      .o_reg_write                (o_reg_write),
      .o_mem_read                 (o_mem_read),
      .o_mem_write                (o_mem_write),
      .o_hazard_count             (o_hazard_count)
   );

   typedef struct {
      logic          v;
      logic [4:0]    rw;
      logic          care_rw;
      logic [2:0]    fl;
      logic [31:0]   imm;
      logic          care_imm;
      logic [10:0]   pc;
      logic          wr, mr, mw;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   n_vec = 0;
   int   n_err = 0;

   localparam logic [31:0] LW5   = 32'h8C25_0004;
   localparam logic [31:0] ADD6  = 32'h00A2_3020;
   localparam logic [31:0] LW0   = 32'h8C20_0000;
   localparam logic [31:0] ADD60 = 32'h0000_3020;
   localparam logic [31:0] JAL   = 32'h0C00_0010;
   localparam logic [31:0] ANDI  = 32'h3063_8001;
   localparam logic [31:0] ADDI  = 32'h2063_8001;
   localparam logic [31:0] SLL   = 32'h0002_20C0;
   localparam logic [31:0] BEQ   = 32'h1022_FFFF;
   localparam logic [31:0] LWCH  = 32'h8CA5_0000;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [4:0] rw, input logic care_rw,
                               input logic [2:0] fl, input logic [31:0] imm, input logic care_imm,
                               input logic [10:0] pc, input logic wr, input logic mr,
                               input logic mw, input logic [CW-1:0] cnt);
      exp_t e;
      e.v = v; e.rw = rw; e.care_rw = care_rw; e.fl = fl; e.imm = imm;
      e.care_imm = care_imm; e.pc = pc; e.wr = wr; e.mr = mr; e.mw = mw; e.cnt = cnt;
      return e;
   endfunction

   function automatic exp_t bubble(input logic [CW-1:0] cnt);
      return mk(1'b0, 5'd0, 1'b1, 3'b000, 32'd0, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, cnt);
   endfunction

   task automatic compare(input exp_t e);
      chk("valid", o_valid, e.v);
      chk("flag", o_flag_branch, e.fl);
      chk("reg_write", o_reg_write, e.wr);
      chk("mem_read", o_mem_read, e.mr);
      chk("mem_write", o_mem_write, e.mw);
      chk("pc", o_pc, e.pc);
      chk("hazard_count", o_hazard_count, e.cnt);
      if (e.care_rw)  chk("reg_W", o_reg_W, e.rw);
      if (e.care_imm) chk("immediate", o_immediate, e.imm);
   endtask

   task automatic step(input logic [31:0] ins, input logic [10:0] pc, input logic en,
                       input logic vl, input logic fl, input logic st,
                       input logic exp_stall, input exp_t e);
      i_instruction = ins; i_pc = pc; i_enable = en; i_valid = vl;
      i_flush = fl; i_stall_ext = st;
      #1;
      chk("stall_fetch", o_stall_fetch, exp_stall);
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare(sb.pop_front());
      last = e;
   endtask

   initial begin
      int cnt_m;
      logic prev_load;
      rst_n = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
      i_stall_ext = 1'b0; i_instruction = LW5; i_pc = 11'd0;
      repeat (2) @(posedge clk);
      #1;
      compare(bubble('0));
      rst_n = 1'b1;

      step(LW5,   11'd1, 1, 1, 0, 0, 0, mk(1, 5, 1, 3'b000, 32'h4, 1, 11'd1, 1, 1, 0, 0));
      step(ADD6,  11'd2, 1, 1, 0, 0, 1, bubble(1));
      step(ADD6,  11'd2, 1, 1, 0, 0, 0, mk(1, 6, 1, 3'b000, 0, 0, 11'd2, 1, 0, 0, 1));
      step(LW0,   11'd3, 1, 1, 0, 0, 0, mk(1, 0, 1, 3'b000, 0, 1, 11'd3, 0, 1, 0, 1));
      step(ADD60, 11'd4, 1, 1, 0, 0, 0, mk(1, 6, 1, 3'b000, 0, 0, 11'd4, 1, 0, 0, 1));
      step(JAL,   11'd5, 1, 1, 0, 0, 0, mk(1, 31, 1, 3'b110, 0, 0, 11'd5, 1, 0, 0, 1));
      step(ANDI,  11'd6, 1, 1, 0, 0, 0, mk(1, 3, 1, 3'b000, 32'h0000_8001, 1, 11'd6, 1, 0, 0, 1));
      step(ADDI,  11'd7, 1, 1, 0, 0, 0, mk(1, 3, 1, 3'b000, 32'hFFFF_8001, 1, 11'd7, 1, 0, 0, 1));
      step(SLL,   11'd8, 1, 1, 0, 0, 0, mk(1, 4, 1, 3'b000, 32'd3, 1, 11'd8, 1, 0, 0, 1));
      step(BEQ,   11'd9, 1, 1, 0, 0, 0, mk(1, 0, 0, 3'b011, 32'hFFFF_FFFF, 1, 11'd9, 0, 0, 0, 1));
      step(LW5,   11'd10, 1, 1, 0, 0, 0, mk(1, 5, 1, 3'b000, 32'h4, 1, 11'd10, 1, 1, 0, 1));
      // Flush beats the load-use hazard: bubble, no stall, no count.
      step(ADD6,  11'd11, 1, 1, 1, 0, 0, bubble(1));
      step(LW5,   11'd12, 1, 1, 0, 0, 0, mk(1, 5, 1, 3'b000, 32'h4, 1, 11'd12, 1, 1, 0, 1));
      for (int k = 0; k < 4; k++)
         step($urandom, 11'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 0, last);
      step(ADD6,  11'd13, 1, 1, 0, 1, 1, last);
      step(ADD6,  11'd13, 1, 1, 0, 0, 1, bubble(2));
      step(ADD6,  11'd13, 1, 1, 0, 0, 0, mk(1, 6, 1, 3'b000, 0, 0, 11'd13, 1, 0, 0, 2));

      // Reset asserted while a load-use stall is pending.
      step(LW5,   11'd14, 1, 1, 0, 0, 0, mk(1, 5, 1, 3'b000, 32'h4, 1, 11'd14, 1, 1, 0, 2));
      i_instruction = ADD6; i_pc = 11'd15;
      #1;
      chk("stall_pre_reset", o_stall_fetch, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      compare(bubble('0));
      chk("stall_in_reset", o_stall_fetch, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(ADD6,  11'd15, 1, 1, 0, 0, 0, mk(1, 6, 1, 3'b000, 0, 0, 11'd15, 1, 0, 0, 0));

      // Back-to-back dependent loads drive the counter into saturation.
      cnt_m = 0;
      prev_load = 1'b0;
      for (int k = 0; k < 2 * (2 ** CW) + 8; k++) begin
         if (prev_load) begin
            if (cnt_m < 2 ** CW - 1) cnt_m++;
            step(LWCH, 11'd16, 1, 1, 0, 0, 1, bubble(CW'(cnt_m)));
            prev_load = 1'b0;
         end else begin
            step(LWCH, 11'd16, 1, 1, 0, 0, 0,
                 mk(1, 5, 1, 3'b000, 32'd0, 1, 11'd16, 1, 1, 0, CW'(cnt_m)));
            prev_load = 1'b1;
         end
      end
      chk("count_saturated", o_hazard_count, {CW{1'b1}});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
